rle_stream_decompressor: RTL and testbench

- Sequential run-length decoder for binary rows (alternating runs of 0s and 1s), used on the IO path ahead of the DCNN row buffers.
- Accepts compressed words over a valid/ready handshake and decodes one count field per clock.
- A row may span several input words. The start digit is selectable per row.
- Emits one ROW_SIZE-bit row per output handshake, with short-row and overflow status.

---
 rtl/rle_stream_decompressor.sv | 163 ++++++++++++++++
 tb/tb_rle_stream_decompressor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rle_stream_decompressor.sv
// Run-length decoder: turns words of count fields into ROW_SIZE-bit rows of alternating digits.
// Decodes one field per clock; a row may continue across several input words.
//
// state  | meaning
// IDLE   | waiting for a compressed word (a row may be open from the previous word)
// DECODE | consuming one count field per cycle from the shift register
// OUTPUT | holding the finished row until the consumer takes it
module rle_stream_decompressor #(
  parameter int SECTION_SIZE = 4,
  parameter int ROW_SIZE     = 16,
  parameter int WORD_SIZE    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic                 in_first_digit,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ROW_SIZE-1:0]  out_data,
  output logic                 out_short,
  output logic                 out_error,
  output logic                 busy
);

  localparam int FIELDS = WORD_SIZE / SECTION_SIZE;
  localparam int IDX_W  = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  // Sum path must hold a full row plus the largest count without wrapping.
  localparam int FILL_W = $clog2(ROW_SIZE + 2**SECTION_SIZE);
  localparam logic [FILL_W-1:0] ROW_FILL = FILL_W'(ROW_SIZE);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FIELDS - 1);

  typedef enum logic [1:0] {IDLE, DECODE, OUTPUT} stateT;

  stateT                   state, nextState;
  logic [WORD_SIZE-1:0]    shiftReg;
  logic [IDX_W-1:0]        fieldIdx;
  logic [FILL_W-1:0]       fill;
  logic                    curDigit;
  logic                    rowOpen;
  logic [ROW_SIZE-1:0]     rowReg;
  logic                    shortFlag;
  logic                    errorFlag;

  logic [SECTION_SIZE-1:0] fieldVal;
  logic [FILL_W-1:0]       sumFill;
  logic                    fieldZero;
  logic                    overflow;
  logic                    rowFull;
  logic                    lastField;
  logic [ROW_SIZE-1:0]     runMask;
  logic [ROW_SIZE-1:0]     rowNext;

  assign fieldVal  = shiftReg[SECTION_SIZE-1:0];
  assign sumFill   = fill + FILL_W'(fieldVal);
  assign fieldZero = (fieldVal == '0);
  assign overflow  = (sumFill > ROW_FILL);
  assign rowFull   = (sumFill == ROW_FILL);
  assign lastField = (fieldIdx == LAST_IDX);

  // Row position p (MSB = 0) is covered when fill <= p < fill+n; an overflowing run is clipped at the row end.
  always_comb begin
    runMask = '0;
    for (int i = 0; i < ROW_SIZE; i++) begin
      if ((FILL_W'(ROW_SIZE - 1 - i) >= fill) && (FILL_W'(ROW_SIZE - 1 - i) < sumFill)) begin
        runMask[i] = 1'b1;
      end
    end
  end

  assign rowNext = curDigit ? (rowReg | runMask) : (rowReg & ~runMask);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (in_valid) nextState = DECODE;
      end
      DECODE: begin
        if (fieldZero || overflow || rowFull) begin
          nextState = OUTPUT;
        end else if (lastField) begin
          nextState = IDLE;
        end
      end
      OUTPUT: begin
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = rst && (state == IDLE);
    out_valid = (state == OUTPUT);
    busy      = (state != IDLE) || rowOpen;
  end

  assign out_data  = rowReg;
  assign out_short = shortFlag;
  assign out_error = errorFlag;

  always_ff @(posedge clk) begin
    if (!rst) begin
      shiftReg  <= '0;
      fieldIdx  <= '0;
      fill      <= '0;
      curDigit  <= 1'b0;
      rowOpen   <= 1'b0;
      rowReg    <= '0;
      shortFlag <= 1'b0;
      errorFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shiftReg <= in_data;
            fieldIdx <= '0;
            if (!rowOpen) begin
              curDigit <= in_first_digit;
              fill     <= '0;
              rowReg   <= '0;
            end
          end
        end
        DECODE: begin
          if (fieldZero) begin
            shortFlag <= (fill < ROW_FILL);
          end else if (overflow) begin
            rowReg    <= rowNext;
            fill      <= ROW_FILL;
            errorFlag <= 1'b1;
          end else begin
            rowReg   <= rowNext;
            fill     <= sumFill;
            curDigit <= ~curDigit;
            shiftReg <= shiftReg >> SECTION_SIZE;
            fieldIdx <= fieldIdx + IDX_W'(1);
            if (!rowFull && lastField) rowOpen <= 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready) begin
            rowOpen   <= 1'b0;
            shortFlag <= 1'b0;
            errorFlag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_stream_decompressor.sv
// Directed bench for rle_stream_decompressor: hand-computed rows, latencies, backpressure and reset abort.
module tb_rle_stream_decompressor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_first_digit = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_short;
  logic        out_error;
  logic        busy;

  int checkCount = 0;
  int errorCount = 0;
  int cycle = 0;

  rle_stream_decompressor #(
    .SECTION_SIZE(4),
    .ROW_SIZE(16),
    .WORD_SIZE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_first_digit(in_first_digit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_short(out_short),
    .out_error(out_error),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents a word at a falling edge; returns the cycle number of the accepting cycle.
  task automatic sendWord(input logic [15:0] data, input logic digit, output int acceptCycle);
    int waitCount;
    waitCount = 0;
    @(negedge clk);
    in_data = data;
    in_first_digit = digit;
    in_valid = 1'b1;
    while (!in_ready && waitCount < 50) begin
      @(negedge clk);
      waitCount++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    acceptCycle = cycle;
    @(negedge clk);
    in_valid = 1'b0;
    in_first_digit = 1'b0;
  endtask

  task automatic waitOut(input string tag, input int acceptCycle, input int expLatency,
                         input logic [15:0] expData, input logic expShort, input logic expError);
    int waitCount;
    waitCount = 0;
    while (!out_valid && waitCount < 50) begin
      @(negedge clk);
      waitCount++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_latency"}, cycle - acceptCycle, expLatency);
    check({tag, "_data"}, {16'd0, out_data}, {16'd0, expData});
    check({tag, "_short"}, {31'd0, out_short}, {31'd0, expShort});
    check({tag, "_error"}, {31'd0, out_error}, {31'd0, expError});
  endtask

  task automatic takeOut(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_flags"}, {30'd0, out_short, out_error}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_flags", {30'd0, out_short, out_error}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // Full row 4,4,4,4 starting with 0
    sendWord(16'h4444, 1'b0, t);
    waitOut("full", t, 5, 16'h0F0F, 1'b0, 1'b0);
    takeOut("full");

    // 5,3 then zero terminator
    sendWord(16'h0035, 1'b0, t);
    waitOut("short", t, 4, 16'h0700, 1'b1, 1'b0);
    takeOut("short");

    // Zero field first: empty short row
    sendWord(16'h0000, 1'b1, t);
    waitOut("empty", t, 2, 16'h0000, 1'b1, 1'b0);
    takeOut("empty");

    // Continuation across two words; digit carries over
    sendWord(16'h3333, 1'b0, t);
    repeat (4) @(negedge clk);
    check("cont_busy", {31'd0, busy}, 32'd1);
    check("cont_in_ready", {31'd0, in_ready}, 32'd1);
    check("cont_no_out", {31'd0, out_valid}, 32'd0);
    sendWord(16'h0004, 1'b1, t);
    waitOut("cont", t, 2, 16'h1C70, 1'b0, 1'b0);
    takeOut("cont");

    // Overflow with start digit 1, then hold under backpressure
    sendWord(16'h00FF, 1'b1, t);
    waitOut("ovf", t, 3, 16'hFFFE, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data = 16'h1111;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_data", {16'd0, out_data}, 32'h0000FFFE);
      check("bp_error", {31'd0, out_error}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    takeOut("bp");
    @(negedge clk);
    check("bp_single", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of decoding
    sendWord(16'h4444, 1'b0, t);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_rst_quiet", {30'd0, out_valid, busy}, 32'd0);
    sendWord(16'h0088, 1'b1, t);
    waitOut("after_rst", t, 3, 16'hFF00, 1'b0, 1'b0);
    takeOut("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
